mru_button_arbiter: RTL and testbench
=====================================

MRU_BUTTON_ARBITER -- requirements
Module: mru_button_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_TICKS, default 2, meaning the number of tick pulses a button must stay held before it qualifies; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; it SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port tick, input, 1, the one-clk-wide timebase pulse from the timer (1 s period).
REQ-005 The block SHALL have ports b1, b2, b3, b4, input, 1 each, the synchronized button levels; high means pressed.
REQ-006 The block SHALL have port use_ready, input, 1, asserted by the MRU tracker when it accepts an event.
REQ-007 The block SHALL have port use_valid, output, 1, asserted while a qualified use event is offered.
REQ-008 The block SHALL have port use_id, output, 2, the index of the offered button (0 = b1 .. 3 = b4).
REQ-009 The block SHALL have port use_onehot, output, 4, equal to 1 << use_id while use_valid is high, else 0.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, QUALIFY, ISSUE and RELEASE.
REQ-012 IDLE: if any of b1..b4 is high, it SHALL pick a winner round-robin, starting at index ptr+1 mod 4; it SHALL then load cand <= winner and cnt <= 0, and go to QUALIFY.
REQ-013 A tick in the same cycle as the IDLE selection SHALL NOT be counted.
REQ-014 QUALIFY: if the cand button is low, the block SHALL return to IDLE with no event; this check has priority over a tick in that cycle.
REQ-015 QUALIFY: on a tick with the cand button high, cnt SHALL increment; when the incremented value equals HOLD_TICKS, the FSM SHALL go to ISSUE.
REQ-016 QUALIFY: presses of non-candidate buttons SHALL be ignored and SHALL NOT change cand.
REQ-017 ISSUE: use_valid SHALL be 1 and use_id SHALL equal cand, held stable until use_ready is sampled high.
REQ-018 ISSUE with use_ready high: the block SHALL set ptr <= cand and go to RELEASE; use_valid SHALL drop in the next cycle.
REQ-019 ISSUE: releasing the cand button SHALL NOT withdraw the event (valid/ready handshake rule: no retraction).
REQ-020 RELEASE: the block SHALL wait until the cand button is low, then go to IDLE; a continuous hold SHALL therefore produce exactly one event.
REQ-021 Latency: use_valid SHALL rise one clk after the HOLD_TICKS-th qualifying tick.
REQ-022 cnt SHALL be 4 bits and SHALL never wrap, because it saturates by state exit.
REQ-023 tick SHALL be ignored in IDLE, ISSUE and RELEASE.

Reset
REQ-024 While rst=0 the block SHALL force state=IDLE, cnt=0, cand=0, and ptr=3 (b1 highest first priority).
REQ-025 While rst=0 the outputs SHALL be use_valid=0, use_id=0, use_onehot=0 and busy=0.
REQ-026 Reset asserted mid-operation, in any state, SHALL abandon the pending event with no partial output.
REQ-027 After rst deasserts, the first clk edge SHALL behave as IDLE.

Structure
REQ-028 Package mru_pkg SHALL hold NUM_BTN=4, the btn_id_t typedef (logic [1:0]) and the arb_state_t enum.
REQ-029 Round-robin selection SHALL be a combinational sub-module mru_rr_pick (inputs req[3:0] and ptr; outputs gnt_id and any_req), instantiated once.
REQ-030 The FSM, counter and pointer SHALL reside in mru_button_arbiter.

Verification
REQ-031 The bench SHALL cover: rst=0 with any inputs -> all outputs 0 and busy=0; after rst=1 with buttons low for 3 ticks -> use_valid stays 0.
REQ-032 The bench SHALL cover: b1 held, use_ready=1 -> no valid after tick 1; use_valid=1 with use_id=0 and use_onehot=0001 one clk after tick 2; exactly one event for a 5-tick hold.
REQ-033 The bench SHALL cover: b1 and b3 raised together from reset (ptr=3) -> event id=0; hold both again after release -> event id=2 (round robin).
REQ-034 The bench SHALL cover: b2 pressed, released before tick 2 -> no event, FSM back in IDLE, busy=0.
REQ-035 The bench SHALL cover: b4 qualified with use_ready=0 for 7 clks and b4 released meanwhile -> use_valid and id=3 held; use_ready=1 -> one-cycle handshake, then IDLE.
REQ-036 The bench SHALL cover: rst pulsed low while in ISSUE -> use_valid=0 immediately (asynchronous), ptr=3, and no event after release.

Source files
------------

// File: rtl/mru_pkg.sv
// Shared types for the MRU button arbiter: button count, button index
// type, arbiter FSM states and a small index-to-onehot helper.
package mru_pkg;

    localparam int NUM_BTN = 4;

    typedef logic [1:0] btn_id_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    function automatic logic [NUM_BTN-1:0] id2onehot(input btn_id_t id);
        return NUM_BTN'(1) << id;
    endfunction

endpackage

// File: rtl/mru_rr_pick.sv
// Combinational round-robin picker: the first asserted request at or
// after ptr+1 (mod NUM_BTN) wins.
module mru_rr_pick
    import mru_pkg::*;
(
    input  logic [NUM_BTN-1:0] req,
    input  btn_id_t            ptr,
    output btn_id_t            gnt_id,
    output logic               any_req
);

    btn_id_t idx;

    always_comb begin
        gnt_id  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            idx = ptr + btn_id_t'(i + 1);
            if (req[idx] && !any_req) begin
                gnt_id  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mru_button_arbiter.sv
// Qualifies a held button over HOLD_TICKS timer ticks and offers exactly
// one use event per continuous hold over a valid/ready handshake.
module mru_button_arbiter
    import mru_pkg::*;
#(
    parameter int unsigned HOLD_TICKS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               b1,
    input  logic               b2,
    input  logic               b3,
    input  logic               b4,
    input  logic               use_ready,
    output logic               use_valid,
    output btn_id_t            use_id,
    output logic [NUM_BTN-1:0] use_onehot,
    output logic               busy
);

    localparam logic [3:0] HOLD_CNT = 4'(HOLD_TICKS);

    arb_state_t         state_q;
    logic [3:0]         cnt_q;
    logic [3:0]         cnt_d;
    btn_id_t            cand_q;
    btn_id_t            ptr_q;
    logic               valid_q;
    btn_id_t            id_q;
    logic               busy_q;

    logic [NUM_BTN-1:0] btn;
    btn_id_t            win_id;
    logic               any_btn;
    logic               cand_held;

    assign btn       = {b4, b3, b2, b1};
    assign cand_held = btn[cand_q];
    assign cnt_d     = cnt_q + 4'd1;

    mru_rr_pick u_pick (
        .req     (btn),
        .ptr     (ptr_q),
        .gnt_id  (win_id),
        .any_req (any_btn)
    );

    // ptr resets to 3 so the first search starts at b1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            ptr_q   <= 2'd3;
            valid_q <= 1'b0;
            id_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_btn) begin
                        cand_q  <= win_id;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    // A dropped candidate beats a coincident tick.
                    if (!cand_held) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (tick) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == HOLD_CNT) begin
                            valid_q <= 1'b1;
                            id_q    <= cand_q;
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (use_ready) begin
                        ptr_q   <= cand_q;
                        valid_q <= 1'b0;
                        id_q    <= '0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!cand_held) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    id_q    <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign use_valid  = valid_q;
    assign use_id     = id_q;
    assign use_onehot = valid_q ? id2onehot(id_q) : '0;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mru_button_arbiter.sv
// Directed bench for mru_button_arbiter with HOLD_TICKS=2.
module tb_mru_button_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, b4 = 1'b0;
    logic       use_ready = 1'b0;
    logic       use_valid;
    logic [1:0] use_id;
    logic [3:0] use_onehot;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int ev_cnt = 0;

    mru_button_arbiter #(.HOLD_TICKS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .b1         (b1),
        .b2         (b2),
        .b3         (b3),
        .b4         (b4),
        .use_ready  (use_ready),
        .use_valid  (use_valid),
        .use_id     (use_id),
        .use_onehot (use_onehot),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (use_valid && use_ready) ev_cnt++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] id,
                           input logic [3:0] oh, input logic bz);
        chk({tag, ".valid"}, {7'd0, use_valid}, {7'd0, v});
        chk({tag, ".id"}, {6'd0, use_id}, {6'd0, id});
        chk({tag, ".onehot"}, {4'd0, use_onehot}, {4'd0, oh});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, bz});
    endtask

    initial begin
        // Reset held with every input high: outputs must stay zero.
        b1 = 1; b2 = 1; b3 = 1; b4 = 1; tick = 1; use_ready = 1;
        repeat (3) step();
        chk_out("rst_all_hi", 0, 0, 4'b0000, 0);
        b1 = 0; b2 = 0; b3 = 0; b4 = 0; tick = 0; use_ready = 0;
        step();
        rst = 1;
        repeat (3) begin do_tick(); step(); end
        chk_out("idle_ticks", 0, 0, 4'b0000, 0);

        // b1 held through 5 ticks: one event after tick 2.
        b1 = 1; use_ready = 1;
        step();
        chk("b1.busy_qual", {7'd0, busy}, 8'd1);
        do_tick();
        chk("b1.tick1_valid", {7'd0, use_valid}, 8'd0);
        step();
        do_tick();
        chk_out("b1.tick2", 1, 0, 4'b0001, 1);
        step();
        chk("b1.valid_drop", {7'd0, use_valid}, 8'd0);
        repeat (3) begin do_tick(); step(); end
        chk("b1.one_event", ev_cnt[7:0], 8'd1);
        chk("b1.no_revalid", {7'd0, use_valid}, 8'd0);
        b1 = 0;
        step();
        chk("b1.idle_busy", {7'd0, busy}, 8'd0);

        // Fresh reset, b1+b3 together: id 0 first, then id 2.
        rst = 0; step(); rst = 1; step();
        b1 = 1; b3 = 1;
        step();
        do_tick(); do_tick();
        chk_out("rr.first", 1, 0, 4'b0001, 1);
        step();
        b1 = 0; b3 = 0;
        step();
        b1 = 1; b3 = 1;
        step();
        do_tick(); do_tick();
        chk_out("rr.second", 1, 2, 4'b0100, 1);
        step();
        b1 = 0; b3 = 0;
        step();
        chk("rr.events", ev_cnt[7:0], 8'd3);

        // b2 released before tick 2: no event, back to idle.
        b2 = 1;
        step();
        do_tick();
        b2 = 0;
        step();
        chk_out("abort", 0, 0, 4'b0000, 0);
        repeat (2) do_tick();
        chk("abort.no_valid", {7'd0, use_valid}, 8'd0);
        chk("abort.events", ev_cnt[7:0], 8'd3);

        // b4 qualified with ready low; release must not retract the event.
        use_ready = 0; b4 = 1;
        step();
        do_tick(); do_tick();
        b4 = 0;
        for (int i = 0; i < 7; i++) begin
            chk_out($sformatf("hold%0d", i), 1, 3, 4'b1000, 1);
            step();
        end
        use_ready = 1;
        step();
        chk("hs.valid_drop", {7'd0, use_valid}, 8'd0);
        chk("hs.events", ev_cnt[7:0], 8'd4);
        step();
        chk("hs.idle_busy", {7'd0, busy}, 8'd0);

        // Async reset while in ISSUE.
        use_ready = 0; b3 = 1;
        step();
        do_tick(); do_tick();
        chk_out("pre_rst", 1, 2, 4'b0100, 1);
        #2 rst = 0;
        #1;
        chk_out("async_rst", 0, 0, 4'b0000, 0);
        step();
        rst = 1; b3 = 0; use_ready = 1;
        repeat (3) begin do_tick(); step(); end
        chk("post_rst.no_valid", {7'd0, use_valid}, 8'd0);
        chk("post_rst.events", ev_cnt[7:0], 8'd4);
        // ptr back at 3: b1 must beat b3.
        b1 = 1; b3 = 1;
        step();
        do_tick(); do_tick();
        chk_out("post_rst.ptr", 1, 0, 4'b0001, 1);
        step();
        b1 = 0; b3 = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
